// File: rtl/mold_pipe_sched.sv
// mold_pipe_sched: routes MoldUDP64 primary/overlap streams onto two pipes, tags messages with sequence numbers, checks counts.
// Optional sequence-gap detection is enabled by defining MOLD_PIPE_SCHED_GAP_DETECT_EN.
module mold_pipe_sched #(
  parameter int AXI_DATA_W = 64,
  parameter int KEEP_LW    = 3,
  parameter int OV_DATA_W  = 48,
  parameter int OV_KEEP_LW = 3,
  parameter int SEQ_W      = 64,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic                  init_v_i,
  input  logic                  last_i,
  input  logic [SEQ_W-1:0]      seq_num_i,
  input  logic [CNT_W-1:0]      msg_cnt_i,
  input  logic                  start_i,
  input  logic [AXI_DATA_W-1:0] data_i,
  input  logic [KEEP_LW-1:0]    len_i,
  input  logic                  msg_end_v_i,
  input  logic                  ov_valid_i,
  input  logic                  ov_start_i,
  input  logic [OV_DATA_W-1:0]  ov_data_i,
  input  logic [OV_KEEP_LW-1:0] ov_len_i,
  output logic                  p0_valid_o,
  output logic                  p0_start_o,
  output logic [AXI_DATA_W-1:0] p0_data_o,
  output logic [KEEP_LW-1:0]    p0_len_o,
  output logic [SEQ_W-1:0]      p0_seq_o,
  output logic                  p1_valid_o,
  output logic                  p1_start_o,
  output logic [AXI_DATA_W-1:0] p1_data_o,
  output logic [KEEP_LW-1:0]    p1_len_o,
  output logic [SEQ_W-1:0]      p1_seq_o,
  output logic                  sel_o,
  output logic                  cnt_err_o,
  output logic                  drop_o,
  output logic                  gap_v_o,
  output logic [SEQ_W-1:0]      gap_len_o
);
  typedef enum logic {IDLE, PKT} state_t;
  state_t state_q, state_n;
  logic acc, acc_init, in_pkt, ov_ok, cur_sel, p_start, o_start, end_b;
  logic sel_q, sel_n, err_n, drop_n;
  logic [1:0] pri, ovl, v_n, v_q, s_n, s_q;
  logic [SEQ_W-1:0] seq_q, seq_base, seq_n;
  logic [CNT_W-1:0] rem_q, rem_base, rem_n;
  logic [1:0][AXI_DATA_W-1:0] d_n, d_q;
  logic [1:0][KEEP_LW-1:0] l_n, l_q;
  logic [1:0][SEQ_W-1:0] q_n, q_q;
  assign in_pkt   = state_q == PKT;
  assign acc_init = valid_i & init_v_i;
  assign acc      = valid_i & (init_v_i | in_pkt);
  always_ff @(posedge clk)
    state_q <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state_q;
    if (acc_init) state_n = last_i ? IDLE : PKT;
    else if (acc && last_i) state_n = IDLE;
  end
  // An init beat always restarts on pipe 0 with the header's sequence and count.
  always_comb begin
    cur_sel  = acc_init ? 1'b0 : sel_q;
    ov_ok    = ov_valid_i & (acc_init | in_pkt);
    p_start  = acc & start_i;
    o_start  = ov_ok & ov_start_i;
    end_b    = acc & msg_end_v_i;
    seq_base = acc_init ? seq_num_i : seq_q;
    seq_n    = seq_base + SEQ_W'(p_start) + SEQ_W'(o_start);
    rem_base = acc_init ? ((msg_cnt_i == '1) ? '0 : msg_cnt_i) : rem_q;
    rem_n    = (end_b && rem_base != '0) ? rem_base - CNT_W'(1) : rem_base;
    err_n    = (acc_init & in_pkt) | (end_b & (rem_base == '0)) | (acc & last_i & (rem_n != '0));
    drop_n   = valid_i & ~init_v_i & ~in_pkt;
    sel_n    = acc ? cur_sel ^ (end_b & ov_valid_i) : sel_q;
    pri      = acc ? (cur_sel ? 2'b10 : 2'b01) : 2'b00;
    ovl      = ov_ok ? (cur_sel ? 2'b01 : 2'b10) : 2'b00;
    for (int i = 0; i < 2; i++) begin
      v_n[i] = pri[i] | ovl[i];
      s_n[i] = pri[i] ? start_i : ovl[i] & ov_start_i;
      d_n[i] = pri[i] ? data_i : ovl[i] ? AXI_DATA_W'(ov_data_i) : '0;
      l_n[i] = pri[i] ? len_i : ovl[i] ? KEEP_LW'(ov_len_i) : '0;
      q_n[i] = (pri[i] & start_i) ? seq_base :
               (ovl[i] & ov_start_i) ? seq_base + SEQ_W'(p_start) : q_q[i];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q     <= 1'b0;
      seq_q     <= '0;
      rem_q     <= '0;
      v_q       <= '0;
      s_q       <= '0;
      d_q       <= '0;
      l_q       <= '0;
      q_q       <= '0;
      cnt_err_o <= 1'b0;
      drop_o    <= 1'b0;
    end else begin
      sel_q     <= sel_n;
      seq_q     <= seq_n;
      rem_q     <= rem_n;
      v_q       <= v_n;
      s_q       <= s_n;
      d_q       <= d_n;
      l_q       <= l_n;
      q_q       <= q_n;
      cnt_err_o <= err_n;
      drop_o    <= drop_n;
    end
  end
  assign sel_o      = sel_q;
  assign p0_valid_o = v_q[0];
  assign p0_start_o = s_q[0];
  assign p0_data_o  = d_q[0];
  assign p0_len_o   = l_q[0];
  assign p0_seq_o   = q_q[0];
  assign p1_valid_o = v_q[1];
  assign p1_start_o = s_q[1];
  assign p1_data_o  = d_q[1];
  assign p1_len_o   = l_q[1];
  assign p1_seq_o   = q_q[1];
`ifdef MOLD_PIPE_SCHED_GAP_DETECT_EN
  logic [SEQ_W-1:0] exp_q;
  logic exp_v_q;
  // A retransmission (seq behind expected) shows up as a large wrapped gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q     <= '0;
      exp_v_q   <= 1'b0;
      gap_v_o   <= 1'b0;
      gap_len_o <= '0;
    end else begin
      gap_v_o   <= acc_init & exp_v_q & (seq_num_i != exp_q);
      gap_len_o <= (acc_init & exp_v_q & (seq_num_i != exp_q)) ? seq_num_i - exp_q : '0;
      if (acc && last_i) begin
        exp_q   <= seq_n;
        exp_v_q <= 1'b1;
      end
    end
  end
`else
  assign gap_v_o   = 1'b0;
  assign gap_len_o = '0;
`endif
endmodule
